// File: rtl/seven_seg_multi.sv
// Binary-to-BCD (double-dabble) converter driving DIGITS active-low seven-segment digits,
// with leading-zero blanking, overflow dashes and a whole-display blink.
`timescale 1ns/1ps
module seven_seg_multi #(
  parameter int DIGITS    = 2,
  parameter int IN_W      = 6,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CW    = $clog2(IN_W + 1);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   data_q, data_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              blank_q, blank_d;
  logic [SEG_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              phase_q, phase_d;

  logic [BCD_W-1:0]  bcd_adj;
  logic [SEG_W-1:0]  seg_dec;
  logic              nz_acc;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
    end
  endgenerate

  // Digit decode; a digit is blanked only if it and every digit above it is zero.
  always_comb begin
    seg_dec = '1;
    nz_acc  = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_acc = nz_acc | (|bcd_q[4*k +: 4]);
      if (blank_q && (k != 0) && !nz_acc)
        seg_dec[7*k +: 7] = SEG_BLANK;
      else
        seg_dec[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    blank_d  = blank_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          blank_d  = blank_lz;
          bcd_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d    = {bcd_adj[BCD_W-2:0], data_q[IN_W-1]};
        data_d   = data_q << 1;
        sticky_d = sticky_q | bcd_adj[BCD_W-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(IN_W - 1))
          state_d = UPDATE;
      end
      UPDATE: begin
        disp_d  = sticky_q ? {DIGITS{SEG_DASH}} : seg_dec;
        ovf_d   = sticky_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blink phase: free-running while enabled, parked "on" while disabled.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!blink_en) begin
      bcnt_d  = '0;
      phase_d = 1'b1;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      blank_q  <= 1'b0;
      disp_q   <= '1;
      ovf_q    <= 1'b0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      blank_q  <= blank_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign seg_out  = phase_q ? disp_q : '1;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_seven_seg_multi.sv
// Directed bench for seven_seg_multi: a 2-digit instance (table vectors, busy-ignore,
// blink, mid-conversion reset) and a 1-digit instance (overflow boundary).
`timescale 1ns/1ps
module tb_seven_seg_multi;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic v2, bl2, be2, rdy2, ovf2;
  logic [5:0] d2;
  logic [13:0] seg2;
  logic v1, bl1, be1, rdy1, ovf1;
  logic [5:0] d1;
  logic [6:0] seg1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] exp_disp2;
  logic [6:0]  exp_disp1;

  seven_seg_multi #(.DIGITS(2), .IN_W(6), .BLINK_DIV(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .blank_lz(bl2), .blink_en(be2), .seg_out(seg2), .ovf(ovf2)
  );

  seven_seg_multi #(.DIGITS(1), .IN_W(6), .BLINK_DIV(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .blank_lz(bl1), .blink_en(be1), .seg_out(seg1), .ovf(ovf1)
  );

  typedef struct packed {
    logic [5:0]  val;
    logic        blz;
    logic [13:0] seg;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic accept2(input logic [5:0] val, input logic blz,
                         input logic [13:0] exp_seg, input logic exp_ovf);
    v2 = 1'b1; d2 = val; bl2 = blz;
    @(posedge clk); #1;
    check("accept2_busy", {31'b0, rdy2}, 32'd0);
    @(negedge clk);
    v2 = 1'b0; d2 = ~val; bl2 = ~blz;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check("convert2_hold_seg", {18'b0, seg2}, {18'b0, exp_disp2});
      check("convert2_busy", {31'b0, rdy2}, 32'd0);
    end
    @(posedge clk); #1;
    check("result2_seg", {18'b0, seg2}, {18'b0, exp_seg});
    check("result2_ovf", {31'b0, ovf2}, {31'b0, exp_ovf});
    check("result2_ready", {31'b0, rdy2}, 32'd1);
    exp_disp2 = exp_seg;
    $display("dut2 accept val=%0d blz=%0b -> seg=%b ovf=%0b", val, blz, seg2, ovf2);
    @(negedge clk);
  endtask

  task automatic accept1(input logic [5:0] val, input logic blz,
                         input logic [6:0] exp_seg, input logic exp_ovf);
    v1 = 1'b1; d1 = val; bl1 = blz;
    @(posedge clk); #1;
    check("accept1_busy", {31'b0, rdy1}, 32'd0);
    @(negedge clk);
    v1 = 1'b0; d1 = ~val;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check("convert1_hold_seg", {25'b0, seg1}, {25'b0, exp_disp1});
    end
    @(posedge clk); #1;
    check("result1_seg", {25'b0, seg1}, {25'b0, exp_seg});
    check("result1_ovf", {31'b0, ovf1}, {31'b0, exp_ovf});
    check("result1_ready", {31'b0, rdy1}, 32'd1);
    exp_disp1 = exp_seg;
    $display("dut1 accept val=%0d blz=%0b -> seg=%b ovf=%0b", val, blz, seg1, ovf1);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{val: 6'd42, blz: 1'b0, seg: {S4, S2}, ovf: 1'b0};
    vecs[1] = '{val: 6'd5,  blz: 1'b1, seg: {SB, S5}, ovf: 1'b0};
    vecs[2] = '{val: 6'd0,  blz: 1'b1, seg: {SB, S0}, ovf: 1'b0};
    vecs[3] = '{val: 6'd0,  blz: 1'b0, seg: {S0, S0}, ovf: 1'b0};
    vecs[4] = '{val: 6'd7,  blz: 1'b0, seg: {S0, S7}, ovf: 1'b0};
    vecs[5] = '{val: 6'd10, blz: 1'b1, seg: {S1, S0}, ovf: 1'b0};
    vecs[6] = '{val: 6'd63, blz: 1'b0, seg: {S6, S3}, ovf: 1'b0};
    vecs[7] = '{val: 6'd9,  blz: 1'b1, seg: {SB, S9}, ovf: 1'b0};
    vecs[8] = '{val: 6'd38, blz: 1'b1, seg: {S3, S8}, ovf: 1'b0};
    vecs[9] = '{val: 6'd19, blz: 1'b0, seg: {S1, S9}, ovf: 1'b0};

    rst_n = 1'b0;
    v2 = 1'b0; d2 = '0; bl2 = 1'b0; be2 = 1'b0;
    v1 = 1'b0; d1 = '0; bl1 = 1'b0; be1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_seg2", {18'b0, seg2}, {18'b0, 14'h3fff});
    check("reset_ovf2", {31'b0, ovf2}, 32'd0);
    check("reset_ready2", {31'b0, rdy2}, 32'd1);
    check("reset_seg1", {25'b0, seg1}, {25'b0, SB});
    check("reset_ovf1", {31'b0, ovf1}, 32'd0);
    check("reset_ready1", {31'b0, rdy1}, 32'd1);
    exp_disp2 = '1;
    exp_disp1 = SB;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      accept2(vecs[i].val, vecs[i].blz, vecs[i].seg, vecs[i].ovf);

    // Single digit: 10^1 boundary and overflow dashes.
    accept1(6'd12, 1'b0, SD, 1'b1);
    accept1(6'd9,  1'b0, S9, 1'b0);
    accept1(6'd10, 1'b0, SD, 1'b1);
    accept1(6'd0,  1'b1, S0, 1'b0);
    accept1(6'd63, 1'b1, SD, 1'b1);
    accept1(6'd3,  1'b1, S3, 1'b0);

    // in_valid held through a conversion with changing data.
    v2 = 1'b1; d2 = 6'd33; bl2 = 1'b0;
    @(posedge clk); #1;
    check("hold_accept_busy", {31'b0, rdy2}, 32'd0);
    @(negedge clk);
    d2 = 6'd7;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check("hold_convert_seg", {18'b0, seg2}, {18'b0, exp_disp2});
      check("hold_convert_busy", {31'b0, rdy2}, 32'd0);
    end
    @(posedge clk); #1;
    check("hold_first_seg", {18'b0, seg2}, {18'b0, S3, S3});
    check("hold_first_ready", {31'b0, rdy2}, 32'd1);
    exp_disp2 = {S3, S3};
    $display("dut2 accept val=33 (valid held) -> seg=%b", seg2);
    @(posedge clk); #1;
    check("hold_second_accept", {31'b0, rdy2}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      check("hold_second_convert_seg", {18'b0, seg2}, {18'b0, exp_disp2});
    end
    @(posedge clk); #1;
    check("hold_second_seg", {18'b0, seg2}, {18'b0, S0, S7});
    check("hold_second_ready", {31'b0, rdy2}, 32'd1);
    exp_disp2 = {S0, S7};
    $display("dut2 accept val=7 (after ready) -> seg=%b", seg2);
    @(negedge clk);
    v2 = 1'b0;
    @(negedge clk);

    // Blink with BLINK_DIV=4: 4 cycles on, 4 off.
    accept2(6'd42, 1'b0, {S4, S2}, 1'b0);
    be2 = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      check("blink_seg", {18'b0, seg2}, (((i / 4) % 2) == 1) ? 32'h3fff : {18'b0, S4, S2});
      check("blink_ovf", {31'b0, ovf2}, 32'd0);
    end
    $display("dut2 blink 13 cycles, last seg=%b", seg2);
    @(negedge clk);
    be2 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("blink_off_steady", {18'b0, seg2}, {18'b0, S4, S2});
    end
    @(negedge clk);

    // Reset on the third CONVERT edge aborts the conversion.
    v2 = 1'b1; d2 = 6'd63; bl2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v2 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_seg", {18'b0, seg2}, 32'h3fff);
    check("abort_ovf", {31'b0, ovf2}, 32'd0);
    check("abort_ready", {31'b0, rdy2}, 32'd1);
    $display("dut2 reset mid-convert -> seg=%b ready=%0b", seg2, rdy2);
    exp_disp2 = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_partial", {18'b0, seg2}, 32'h3fff);
    end
    @(negedge clk);
    accept2(6'd17, 1'b0, {S1, S7}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_multi.md
SEVEN_SEG_MULTI -- requirements
Module: seven_seg_multi

Interface
REQ-001 Parameter DIGITS, default 2: number of decimal display digits, range 1..8.
REQ-002 Parameter IN_W, default 6: binary input width, range 1..27.
REQ-003 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period, minimum 1.
REQ-004 clk  input  1: single rising-edge clock for all state.
REQ-005 rst_n  input  1: reset, synchronous and active-low.
REQ-006 in_valid  input  1: in_data is offered for conversion.
REQ-007 in_ready  output  1: block is idle and can accept a new value.
REQ-008 in_data  input  IN_W: unsigned binary value to display.
REQ-009 blank_lz  input  1: when set, leading-zero digits are blanked; sampled at accept.
REQ-010 blink_en  input  1: when set, the whole display blinks at the BLINK_DIV rate.
REQ-011 seg_out  output  7*DIGITS: active-low segments; digit k (k=0 is units) occupies bits [7k+6:7k], ordered gfedcba.
REQ-012 ovf  output  1: the last accepted value is 10^DIGITS or greater.

Function
REQ-013 Segment codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.
REQ-014 FSM states SHALL be IDLE, CONVERT and UPDATE; in_ready=1 only in IDLE.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; that edge latches in_data and blank_lz, clears the BCD register and shift count, and enters CONVERT.
REQ-016 CONVERT SHALL run exactly IN_W cycles, each cycle a double-dabble step: add 3 to every BCD nibble >=5, then shift left one bit, taking the next input bit MSB-first.
REQ-017 Any 1 shifted out of the top nibble during CONVERT SHALL set a sticky overflow flag for that conversion.
REQ-018 After the IN_W-th shift, the FSM SHALL enter UPDATE; the UPDATE edge writes the display register and ovf, then returns to IDLE.
REQ-019 seg_out and ovf SHALL change exactly IN_W+1 clock edges after the accepting edge; in_ready SHALL reassert on that same edge.
REQ-020 in_valid while in_ready=0 SHALL be ignored and SHALL NOT disturb the conversion in progress.
REQ-021 On overflow, all digits SHALL show dash and ovf=1; otherwise ovf=0.
REQ-022 With latched blank_lz=1, every zero digit above the most significant nonzero digit SHALL show blank; digit 0 is never blanked, so value 0 shows "0".
REQ-023 seg_out SHALL hold the last displayed value between conversions.
REQ-024 Blink SHALL use a free-running counter that toggles a phase bit every BLINK_DIV cycles; while the phase is off, seg_out is all ones.
REQ-025 blink_en=0 SHALL clear the counter and force the phase on; the display register is never altered by blinking.
REQ-026 The blink output gating SHALL take effect within 1 cycle of a phase change; ovf is not affected by blink.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force: state IDLE, in_ready=1 after the edge, seg_out all ones (blank), ovf=0, BCD and shift count 0, blink counter 0, phase on.
REQ-028 Reset during CONVERT or UPDATE SHALL abort the conversion; no partial result is ever displayed.

Verification (DIGITS=2, IN_W=6 unless stated)
REQ-029 Accept 42, blank_lz=0 -> after 7 edges seg_out[13:7]=0011001, [6:0]=0100100, ovf=0, in_ready=1.
REQ-030 Accept 5, blank_lz=1 -> high digit 1111111, low digit 0010010; accept 0, blank_lz=1 -> high 1111111, low 1000000.
REQ-031 DIGITS=1, IN_W=6, accept 12 -> seg_out=0111111, ovf=1; then accept 9 -> seg_out=0010000, ovf=0.
REQ-032 in_valid held with values 33 then 7 during CONVERT -> only 33 is displayed (0110000/0110000); 7 is accepted only once in_ready=1.
REQ-033 BLINK_DIV=4, blink_en=1, display shows 42 -> seg_out alternates 4 cycles all ones / 4 cycles "42"; deassert blink_en -> "42" steady the next cycle.
REQ-034 Accept 63, then rst_n=0 on cycle 3 of CONVERT -> seg_out all ones, ovf=0, in_ready=1; a new accept of 17 then displays 1111001/1111000.
